// File: rtl/alu_pkg.sv
// Shared opcode encoding, FSM state type and flag helper for the sequential ALU.
// Both alu_seq and its iterative mul/div unit import this package.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_DIV = 3'b100;
    localparam logic [2:0] OP_RSV = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        MUL,
        DIV,
        FIN
    } state_e;

    // Two's-complement overflow of a + b. For a - b, pass the inverted MSB of b.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider.
// Handles one bit per clock; fin pulses for one cycle after the last iteration.
module alu_seq_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             go,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             fin,
    output logic             active
);

    localparam int               CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_q, div_d;
    logic             active_q, active_d;
    logic             fin_q, fin_d;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;

    always_comb begin
        acc_d    = acc_q;
        sh_d     = sh_q;
        opb_d    = opb_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        active_d = active_q;
        fin_d    = 1'b0;

        add_sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opb_q} : '0);
        rem_sh  = {acc_q, sh_q[WIDTH-1]};
        // Remainder stays below the divisor, so bit WIDTH of trial is a clean borrow flag.
        trial   = rem_sh - {1'b0, opb_q};

        if (go) begin
            acc_d    = '0;
            sh_d     = op_a;
            opb_d    = op_b;
            div_d    = is_div;
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            if (div_q) begin
                if (!trial[WIDTH]) begin
                    acc_d = trial[WIDTH-1:0];
                    sh_d  = {sh_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = rem_sh[WIDTH-1:0];
                    sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                {acc_d, sh_d} = {add_sum, sh_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                active_d = 1'b0;
                fin_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        acc_q <= acc_d;
        sh_q  <= sh_d;
        opb_q <= opb_d;
        div_q <= div_d;
        if (reset) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
            fin_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
            fin_q    <= fin_d;
        end
    end

    assign hi     = acc_q;
    assign lo     = sh_q;
    assign fin    = fin_q;
    assign active = active_q;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle execute-stage ALU: single-cycle logic/arith ops plus iterative mul/div
// behind a start/busy/done handshake, with registered result and flag outputs.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       sinalOperacao,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic [WIDTH-1:0] resultado,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] sum, diff;
    logic             md_go, md_is_div;
    logic [WIDTH-1:0] md_hi, md_lo;
    logic             md_fin, md_active;

    alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clock  (clock),
        .reset  (reset),
        .go     (md_go),
        .is_div (md_is_div),
        .op_a   (rs),
        .op_b   (rt),
        .hi     (md_hi),
        .lo     (md_lo),
        .fin    (md_fin),
        .active (md_active)
    );

    always_comb begin
        state_d   = state_q;
        res_d     = res_q;
        hi_d      = hi_q;
        ovf_d     = ovf_q;
        dbz_d     = dbz_q;
        done_d    = 1'b0;
        md_go     = 1'b0;
        md_is_div = 1'b0;
        sum       = rs + rt;
        diff      = rs - rt;

        case (state_q)
            IDLE, EXEC, FIN: begin
                if (start) begin
                    state_d = EXEC;
                    done_d  = 1'b1;
                    ovf_d   = 1'b0;
                    dbz_d   = 1'b0;
                    hi_d    = '0;
                    case (sinalOperacao)
                        OP_AND: res_d = rs & rt;
                        OP_OR:  res_d = rs | rt;
                        OP_ADD: begin
                            res_d = sum;
                            ovf_d = signed_ovf(rs[WIDTH-1], rt[WIDTH-1], sum[WIDTH-1]);
                        end
                        OP_SUB: begin
                            res_d = diff;
                            ovf_d = signed_ovf(rs[WIDTH-1], ~rt[WIDTH-1], diff[WIDTH-1]);
                        end
                        OP_SLT: begin
                            res_d    = '0;
                            res_d[0] = (rs < rt);
                        end
                        OP_MUL: begin
                            // Result registers keep the previous values until the unit finishes.
                            hi_d    = hi_q;
                            md_go   = 1'b1;
                            state_d = MUL;
                            done_d  = 1'b0;
                        end
                        OP_DIV: begin
                            if (rt == '0) begin
                                res_d = '1;
                                hi_d  = rs;
                                dbz_d = 1'b1;
                            end else begin
                                hi_d      = hi_q;
                                md_go     = 1'b1;
                                md_is_div = 1'b1;
                                state_d   = DIV;
                                done_d    = 1'b0;
                            end
                        end
                        default: res_d = '0;
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            MUL, DIV: begin
                if (md_fin) begin
                    res_d   = md_lo;
                    hi_d    = md_hi;
                    ovf_d   = (state_q == MUL) && (md_hi != '0);
                    done_d  = 1'b1;
                    state_d = FIN;
                end
            end
            default: state_d = IDLE;
        endcase

        zero_d = (res_d == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            res_q   <= '0;
            hi_q    <= '0;
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    assign resultado   = res_q;
    assign hi          = hi_q;
    assign zero        = zero_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dbz_q;
    assign busy        = md_active;
    assign done        = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH = 32 with hand-computed expectations.
module tb_alu_seq;

    logic        clock;
    logic        reset;
    logic        start;
    logic [2:0]  sinalOperacao;
    logic [31:0] rs, rt;
    logic [31:0] resultado, hi;
    logic        zero, overflow, div_by_zero, busy, done;

    int total = 0;
    int bad   = 0;
    int lat, bcnt;

    alu_seq #(.WIDTH(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .sinalOperacao (sinalOperacao),
        .rs            (rs),
        .rt            (rt),
        .resultado     (resultado),
        .hi            (hi),
        .zero          (zero),
        .overflow      (overflow),
        .div_by_zero   (div_by_zero),
        .busy          (busy),
        .done          (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start         = 1'b1;
        sinalOperacao = op;
        rs            = a;
        rt            = b;
        tick();
        start = 1'b0;
    endtask

    // Issue a mul/div, scramble operands, then count edges until done and busy cycles seen.
    task automatic run_long(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int l, output int bc);
        issue(op, a, b);
        rs = 32'hDEAD_BEEF;
        rt = 32'h0000_0003;
        sinalOperacao = 3'b000;
        l  = 0;
        bc = 0;
        while (!done && l < 60) begin
            if (busy) bc++;
            tick();
            l++;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; sinalOperacao = 3'b000; rs = '0; rt = '0;
        tick();
        tick();
        check("rst_res",  64'(resultado),   64'h0);
        check("rst_hi",   64'(hi),          64'h0);
        check("rst_zero", 64'(zero),        64'h1);
        check("rst_ovf",  64'(overflow),    64'h0);
        check("rst_dbz",  64'(div_by_zero), 64'h0);
        check("rst_busy", 64'(busy),        64'h0);
        check("rst_done", 64'(done),        64'h0);
        reset = 1'b0;
        tick();

        issue(3'b010, 32'h7FFF_FFFF, 32'h0000_0001);
        check("add_done", 64'(done),      64'h1);
        check("add_res",  64'(resultado), 64'h8000_0000);
        check("add_ovf",  64'(overflow),  64'h1);
        check("add_zero", 64'(zero),      64'h0);
        check("add_hi",   64'(hi),        64'h0);
        tick();
        check("add_done_pulse", 64'(done), 64'h0);

        start = 1'b1; sinalOperacao = 3'b110; rs = 32'd5; rt = 32'd5;
        tick();
        check("sub_done", 64'(done),      64'h1);
        check("sub_res",  64'(resultado), 64'h0);
        check("sub_zero", 64'(zero),      64'h1);
        check("sub_ovf",  64'(overflow),  64'h0);
        sinalOperacao = 3'b111; rs = 32'd3; rt = 32'd5;
        tick();
        check("slt_done", 64'(done),      64'h1);
        check("slt_res",  64'(resultado), 64'h1);
        check("slt_zero", 64'(zero),      64'h0);
        start = 1'b0;
        tick();
        check("b2b_idle_done", 64'(done), 64'h0);

        issue(3'b000, 32'h0000_F0F0, 32'h0000_FF00);
        check("and_res", 64'(resultado), 64'h0000_F000);
        issue(3'b001, 32'h0000_F0F0, 32'h0000_FF00);
        check("or_res", 64'(resultado), 64'h0000_FFF0);
        issue(3'b110, 32'h8000_0000, 32'h0000_0001);
        check("subovf_res", 64'(resultado), 64'h7FFF_FFFF);
        check("subovf_ovf", 64'(overflow),  64'h1);
        issue(3'b111, 32'hFFFF_FFFF, 32'h0000_0001);
        check("slt_unsigned", 64'(resultado), 64'h0);
        check("slt_clears_ovf", 64'(overflow), 64'h0);
        issue(3'b101, 32'd9, 32'd3);
        check("rsv_done", 64'(done),      64'h1);
        check("rsv_res",  64'(resultado), 64'h0);
        check("rsv_hi",   64'(hi),        64'h0);
        check("rsv_zero", 64'(zero),      64'h1);
        check("rsv_ovf",  64'(overflow),  64'h0);
        tick();

        run_long(3'b011, 32'h0001_0000, 32'h0001_0000, lat, bcnt);
        check("mul1_lat",  64'(lat),       64'd33);
        check("mul1_busy", 64'(bcnt),      64'd32);
        check("mul1_res",  64'(resultado), 64'h0);
        check("mul1_hi",   64'(hi),        64'h1);
        check("mul1_zero", 64'(zero),      64'h1);
        check("mul1_ovf",  64'(overflow),  64'h1);
        check("mul1_busy_at_done", 64'(busy), 64'h0);

        run_long(3'b011, 32'hFFFF_FFFF, 32'h0000_0002, lat, bcnt);
        check("mul2_lat", 64'(lat),       64'd33);
        check("mul2_res", 64'(resultado), 64'hFFFF_FFFE);
        check("mul2_hi",  64'(hi),        64'h1);
        check("mul2_ovf", 64'(overflow),  64'h1);

        run_long(3'b100, 32'd100, 32'd7, lat, bcnt);
        check("div_lat",  64'(lat),       64'd33);
        check("div_busy", 64'(bcnt),      64'd32);
        check("div_res",  64'(resultado), 64'd14);
        check("div_hi",   64'(hi),        64'd2);
        check("div_ovf",  64'(overflow),  64'h0);
        check("div_dbz",  64'(div_by_zero), 64'h0);

        issue(3'b100, 32'd5, 32'd0);
        check("dbz_done", 64'(done),        64'h1);
        check("dbz_res",  64'(resultado),   64'hFFFF_FFFF);
        check("dbz_hi",   64'(hi),          64'd5);
        check("dbz_flag", 64'(div_by_zero), 64'h1);
        check("dbz_zero", 64'(zero),        64'h0);
        tick();

        issue(3'b100, 32'd100, 32'd7);
        check("ign_busy0",    64'(busy),        64'h1);
        check("ign_dbz_clr",  64'(div_by_zero), 64'h0);
        check("ign_hold_res", 64'(resultado),   64'hFFFF_FFFF);
        tick(); tick(); tick();
        issue(3'b010, 32'd1, 32'd1);
        check("ign_no_done", 64'(done), 64'h0);
        lat = 4;
        while (!done && lat < 60) begin
            tick();
            lat++;
        end
        check("ign_lat", 64'(lat),       64'd33);
        check("ign_res", 64'(resultado), 64'd14);
        check("ign_hi",  64'(hi),        64'd2);
        tick();
        check("ign_single_done", 64'(done),      64'h0);
        check("ign_res_hold",    64'(resultado), 64'd14);

        issue(3'b011, 32'd3, 32'd5);
        for (int i = 0; i < 10; i++) tick();
        check("rstmid_busy_before", 64'(busy), 64'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstmid_busy", 64'(busy),      64'h0);
        check("rstmid_res",  64'(resultado), 64'h0);
        check("rstmid_hi",   64'(hi),        64'h0);
        check("rstmid_zero", 64'(zero),      64'h1);
        check("rstmid_done", 64'(done),      64'h0);
        check("rstmid_ovf",  64'(overflow),  64'h0);

        run_long(3'b011, 32'd6, 32'd7, lat, bcnt);
        check("post_rst_lat",  64'(lat),       64'd33);
        check("post_rst_res",  64'(resultado), 64'd42);
        check("post_rst_hi",   64'(hi),        64'h0);
        check("post_rst_ovf",  64'(overflow),  64'h0);
        check("post_rst_zero", 64'(zero),      64'h0);
        tick();
        check("post_rst_done_end", 64'(done), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
